// File: rtl/wb_pkg.sv
// Shared Wishbone bus types, width constants and the base/mask match helper
// used by the pipelined address decoder.
package wb_pkg;

   localparam int DataWidth    = 32;
   localparam int SelWidth     = 4;
   localparam int MaxAddrWidth = 32;

   typedef struct packed {
      logic                    cyc;
      logic                    stb;
      logic                    we;
      logic [MaxAddrWidth-1:0] addr;
      logic [SelWidth-1:0]     sel;
      logic [DataWidth-1:0]    data;
   } wb_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      logic                 ack;
      logic                 err;
      logic                 stall;
   } wb_rsp_t;

   function automatic logic addr_match(input logic [MaxAddrWidth-1:0] addr,
                                       input logic [MaxAddrWidth-1:0] base,
                                       input logic [MaxAddrWidth-1:0] mask);
      return (addr & mask) == base;
   endfunction

endpackage

// File: rtl/wb_err_slave.sv
// Internal responder for unmapped addresses: answers every accepted request
// with an error exactly one cycle later, one request per cycle.
module wb_err_slave (
   input  logic clk_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic accept_i,
   output logic err_o
);

   logic r_err_pend;

   // Pending-error flag; a master abort discards any pending error.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_err_pend <= 1'b0;
      end else if (clear_i) begin
         r_err_pend <= 1'b0;
      end else begin
         r_err_pend <= accept_i;
      end
   end

   assign err_o = r_err_pend;

endmodule

// File: rtl/wb_decoder.sv
// Pipelined Wishbone 1-to-N address decoder with outstanding tracking,
// same-target ordering and an internal error target for unmapped addresses.
module wb_decoder
   import wb_pkg::*;
#(
   parameter int NumSlaves      = 4,
   parameter int AddrWidth      = 30,
   parameter int MaxOutstanding = 4,
   parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveBase = '0,
   parameter logic [NumSlaves-1:0][AddrWidth-1:0] SlaveMask = '0
) (
   input  logic                                clk_i,
   input  logic                                reset_i,
   input  logic                                wbm_cyc_i,
   input  logic                                wbm_stb_i,
   input  logic                                wbm_we_i,
   input  logic [AddrWidth-1:0]                wbm_addr_i,
   input  logic [SelWidth-1:0]                 wbm_sel_i,
   input  logic [DataWidth-1:0]                wbm_data_i,
   output logic [DataWidth-1:0]                wbm_data_o,
   output logic                                wbm_ack_o,
   output logic                                wbm_err_o,
   output logic                                wbm_stall_o,
   output logic [NumSlaves-1:0]                wbs_cyc_o,
   output logic [NumSlaves-1:0]                wbs_stb_o,
   output logic                                wbs_we_o,
   output logic [AddrWidth-1:0]                wbs_addr_o,
   output logic [SelWidth-1:0]                 wbs_sel_o,
   output logic [DataWidth-1:0]                wbs_data_o,
   input  logic [NumSlaves-1:0][DataWidth-1:0] wbs_data_i,
   input  logic [NumSlaves-1:0]                wbs_ack_i,
   input  logic [NumSlaves-1:0]                wbs_err_i,
   input  logic [NumSlaves-1:0]                wbs_stall_i
);

   localparam int TgtWidth = $clog2(NumSlaves + 1);
   localparam int CntWidth = $clog2(MaxOutstanding + 1);
   localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NumSlaves);
   localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

   logic [CntWidth-1:0]  r_cnt;
   logic [TgtWidth-1:0]  r_tgt;
   logic [TgtWidth-1:0]  w_dec;
   logic                 w_dec_stall;
   logic                 w_sel_ack;
   logic                 w_sel_err;
   logic [DataWidth-1:0] w_sel_data;
   logic                 w_busy;
   logic                 w_block;
   logic                 w_accept;
   logic                 w_rsp;
   logic                 w_err_pend;
   wb_rsp_t              w_rsp_bus;

   // Address decode: scanning from the top down lets the lowest match win.
   always_comb begin
      w_dec = ErrTgt;
      for (int k = NumSlaves - 1; k >= 0; k--) begin
         w_dec = addr_match(32'(wbm_addr_i), 32'(SlaveBase[k]), 32'(SlaveMask[k]))
                 ? TgtWidth'(k) : w_dec;
      end
   end

   // Stall of the decoded slave, and response muxing by the held target.
   always_comb begin
      w_dec_stall = 1'b0;
      w_sel_ack   = 1'b0;
      w_sel_err   = 1'b0;
      w_sel_data  = '0;
      for (int k = 0; k < NumSlaves; k++) begin
         w_dec_stall = w_dec_stall | ((w_dec == TgtWidth'(k)) & wbs_stall_i[k]);
         w_sel_ack   = w_sel_ack   | ((r_tgt == TgtWidth'(k)) & wbs_ack_i[k]);
         w_sel_err   = w_sel_err   | ((r_tgt == TgtWidth'(k)) & wbs_err_i[k]);
         w_sel_data  = (r_tgt == TgtWidth'(k)) ? wbs_data_i[k] : w_sel_data;
      end
   end

   assign w_busy  = (r_cnt != '0);
   // Switching targets is held off until every earlier response is back.
   assign w_block = (r_cnt == CntMax) | (w_busy & (w_dec != r_tgt));

   assign w_rsp_bus.stall = wbm_cyc_i & (w_block | w_dec_stall);
   assign w_rsp_bus.ack   = w_busy & w_sel_ack;
   assign w_rsp_bus.err   = (w_busy & w_sel_err) | w_err_pend;
   assign w_rsp_bus.data  = w_sel_data;

   assign wbm_stall_o = w_rsp_bus.stall;
   assign wbm_ack_o   = w_rsp_bus.ack;
   assign wbm_err_o   = w_rsp_bus.err;
   assign wbm_data_o  = w_rsp_bus.data;

   assign w_accept = wbm_cyc_i & wbm_stb_i & ~w_rsp_bus.stall;
   assign w_rsp    = w_rsp_bus.ack | w_rsp_bus.err;

   assign wbs_we_o   = wbm_we_i;
   assign wbs_addr_o = wbm_addr_i;
   assign wbs_sel_o  = wbm_sel_i;
   assign wbs_data_o = wbm_data_i;

   // Per-slave cycle and strobe generation.
   always_comb begin
      wbs_cyc_o = '0;
      wbs_stb_o = '0;
      for (int k = 0; k < NumSlaves; k++) begin
         wbs_stb_o[k] = wbm_cyc_i & wbm_stb_i & (w_dec == TgtWidth'(k)) & ~w_block;
         wbs_cyc_o[k] = wbm_cyc_i & ((w_busy & (r_tgt == TgtWidth'(k)))
                                     | (w_dec == TgtWidth'(k)));
      end
   end

   // Outstanding-request counter; a dropped cycle abandons everything in flight.
   always_ff @(posedge clk_i) begin
      if (reset_i || !wbm_cyc_i) begin
         r_cnt <= '0;
      end else begin
         case ({w_accept, w_rsp & w_busy})
            2'b10:   r_cnt <= (r_cnt == CntMax) ? r_cnt : r_cnt + CntWidth'(1);
            2'b01:   r_cnt <= r_cnt - CntWidth'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Target of the most recently accepted request.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_tgt <= '0;
      end else if (w_accept) begin
         r_tgt <= w_dec;
      end else begin
         r_tgt <= r_tgt;
      end
   end

   wb_err_slave u_err_slave (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .clear_i  (~wbm_cyc_i),
      .accept_i (w_accept & (w_dec == ErrTgt)),
      .err_o    (w_err_pend)
   );

endmodule

// File: tb/tb_wb_decoder.sv
// Directed plus randomized bench for wb_decoder, checked against a
// queue-based model of outstanding requests built from the decode rules.
module tb_wb_decoder;

   localparam int NS   = 4;
   localparam int AW   = 30;
   localparam int MAXO = 4;
   localparam logic [NS-1:0][AW-1:0] BASES = {30'h400, 30'h400, 30'h100, 30'h000};
   localparam logic [NS-1:0][AW-1:0] MASKS = {30'hC00, 30'hF00, 30'hF00, 30'hF00};

   // Reference address map (slave k: base, mask); 0x2xx/0x3xx/0x8xx+ unmapped.
   int unsigned ref_base[NS] = '{32'h000, 32'h100, 32'h400, 32'h400};
   int unsigned ref_mask[NS] = '{32'hF00, 32'hF00, 32'hF00, 32'hC00};

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  cyc, stb, we;
   logic [AW-1:0]         addr;
   logic [3:0]            sel;
   logic [31:0]           wdat;
   logic [31:0]           m_rdat;
   logic                  m_ack, m_err, m_stall;
   logic [NS-1:0]         s_cyc, s_stb;
   logic                  s_we;
   logic [AW-1:0]         s_addr;
   logic [3:0]            s_sel;
   logic [31:0]           s_wdat;
   logic [NS-1:0][31:0]   s_data;
   logic [NS-1:0]         s_ack, s_err, s_stall;

   int checks = 0;
   int errors = 0;

   int pend_q[$];
   int m_tgt;
   bit m_err_pend;
   bit e_acc, e_rsp;
   int e_dec;

   always #5 clk = ~clk;

   wb_decoder #(
      .NumSlaves(NS), .AddrWidth(AW), .MaxOutstanding(MAXO),
      .SlaveBase(BASES), .SlaveMask(MASKS)
   ) dut (
      .clk_i(clk), .reset_i(rst),
      .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_we_i(we), .wbm_addr_i(addr),
      .wbm_sel_i(sel), .wbm_data_i(wdat), .wbm_data_o(m_rdat),
      .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_stall_o(m_stall),
      .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_we_o(s_we), .wbs_addr_o(s_addr),
      .wbs_sel_o(s_sel), .wbs_data_o(s_wdat), .wbs_data_i(s_data),
      .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_stall_i(s_stall)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_decode(input logic [AW-1:0] a);
      for (int k = 0; k < NS; k++) begin
         if ((32'(a) & ref_mask[k]) == ref_base[k]) return k;
      end
      return NS;
   endfunction

   // Compare every output against the model, 1 time unit after inputs change.
   task automatic settle();
      int cnt;
      bit blk, x_stall, x_ack, x_err;
      logic [31:0] x_data;
      logic [NS-1:0] x_stb, x_cyc;
      #1;
      e_dec = ref_decode(addr);
      cnt = pend_q.size();
      blk = (cnt == MAXO) || (cnt != 0 && e_dec != m_tgt);
      x_stall = cyc && (blk || (e_dec < NS && s_stall[e_dec]));
      x_ack = (cnt != 0) && (m_tgt < NS) && s_ack[m_tgt];
      x_err = ((cnt != 0) && (m_tgt < NS) && s_err[m_tgt]) || m_err_pend;
      x_data = (m_tgt < NS) ? s_data[m_tgt] : 32'h0;
      x_stb = '0;
      x_cyc = '0;
      for (int k = 0; k < NS; k++) begin
         x_stb[k] = cyc && stb && e_dec == k && !blk;
         x_cyc[k] = cyc && ((cnt != 0 && m_tgt == k) || e_dec == k);
      end
      e_acc = cyc && stb && !x_stall;
      e_rsp = x_ack || x_err;
      chk("stall", 32'(m_stall), 32'(x_stall));
      chk("ack", 32'(m_ack), 32'(x_ack));
      chk("err", 32'(m_err), 32'(x_err));
      chk("rdata", m_rdat, x_data);
      chk("stb", 32'(s_stb), 32'(x_stb));
      chk("cyc", 32'(s_cyc), 32'(x_cyc));
      chk("bcast", {s_we, s_sel, 27'(s_addr)}, {we, sel, 27'(addr)});
      chk("wdata", s_wdat, wdat);
   endtask

   // Advance one clock and update the model with what the edge consumed.
   task automatic tick();
      @(posedge clk);
      if (rst || !cyc) begin
         pend_q.delete();
         m_err_pend = 1'b0;
         if (rst) m_tgt = 0;
      end else begin
         if (e_rsp && pend_q.size() > 0) void'(pend_q.pop_front());
         if (e_acc) begin
            pend_q.push_back(e_dec);
            m_tgt = e_dec;
         end
         m_err_pend = e_acc && (e_dec == NS);
      end
      #1;
   endtask

   task automatic req(input bit c, input bit s, input logic [AW-1:0] a);
      cyc = c;
      stb = s;
      addr = a;
   endtask

   initial begin
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0;
      sel = 4'hF; wdat = 32'h0; s_data = '0;
      s_ack = '0; s_err = '0; s_stall = '0;
      m_tgt = 0; m_err_pend = 1'b0; e_acc = 1'b0; e_rsp = 1'b0; e_dec = 0;
      @(posedge clk); #1;
      settle();
      chk("rst_cyc", 32'(s_cyc), 32'h0);
      chk("rst_stb", 32'(s_stb), 32'h0);
      chk("rst_ack_err_stall", {m_ack, m_err, m_stall}, 3'b000);
      tick();
      rst = 1'b0;

      // Single read from ROM
      req(1'b1, 1'b1, 30'h004); settle();
      chk("rom_stb", 32'(s_stb), 32'h1); tick();
      stb = 1'b0; s_ack[0] = 1'b1; s_data[0] = 32'hDEADBEEF; settle();
      chk("rom_ack", 32'(m_ack), 32'h1); chk("rom_data", m_rdat, 32'hDEADBEEF); tick();
      s_ack = '0; req(1'b1, 1'b0, 30'h104); settle();
      chk("rom_cnt0", 32'(s_cyc), 32'h2); tick();

      // Fill to MaxOutstanding, then release with one ack
      for (int i = 0; i < MAXO; i++) begin
         req(1'b1, 1'b1, AW'(32'h010 + 32'(i))); settle();
         chk("fill_nostall", 32'(m_stall), 32'h0); tick();
      end
      settle(); chk("full_stall", 32'(m_stall), 32'h1); chk("full_stb", 32'(s_stb), 32'h0); tick();
      s_ack[0] = 1'b1; settle(); chk("full_ack", 32'(m_ack), 32'h1); tick();
      s_ack = '0; settle(); chk("freed_stall", 32'(m_stall), 32'h0);
      chk("freed_stb", 32'(s_stb), 32'h1); tick();
      stb = 1'b0; s_ack[0] = 1'b1;
      for (int i = 0; i < MAXO; i++) begin settle(); tick(); end
      s_ack = '0;

      // Ordering: slave1 waits for slave0's response
      req(1'b1, 1'b1, 30'h010); settle(); tick();
      addr = 30'h104; settle();
      chk("ord_stall", 32'(m_stall), 32'h1); chk("ord_stb", 32'(s_stb), 32'h0);
      chk("ord_cyc", 32'(s_cyc), 32'h3); tick();
      s_ack[0] = 1'b1; settle(); chk("ord_ack_stall", 32'(m_stall), 32'h1); tick();
      s_ack = '0; settle(); chk("ord_go_stall", 32'(m_stall), 32'h0);
      chk("ord_go_stb", 32'(s_stb), 32'h2); tick();
      stb = 1'b0; s_ack[1] = 1'b1; settle(); chk("ord_s1_ack", 32'(m_ack), 32'h1); tick();
      s_ack = '0;

      // Unmapped address, two strobes back to back
      req(1'b1, 1'b1, 30'h300); settle();
      chk("unm_n_err", 32'(m_err), 32'h0); chk("unm_n_stb", 32'(s_stb), 32'h0);
      chk("unm_n_stall", 32'(m_stall), 32'h0); tick();
      settle(); chk("unm_n1_err", 32'(m_err), 32'h1); chk("unm_n1_stb", 32'(s_stb), 32'h0); tick();
      stb = 1'b0; settle(); chk("unm_n2_err", 32'(m_err), 32'h1); tick();
      settle(); chk("unm_n3_err", 32'(m_err), 32'h0); tick();

      // Abort with two outstanding, late ack ignored
      req(1'b1, 1'b1, 30'h020); settle(); tick(); settle(); tick();
      req(1'b0, 1'b0, 30'h020); settle(); chk("abort_ack0", 32'(m_ack), 32'h0); tick();
      s_ack[0] = 1'b1; settle(); chk("late_ack", 32'(m_ack), 32'h0); tick();
      s_ack = '0; req(1'b1, 1'b0, 30'h104); settle();
      chk("abort_cyc", 32'(s_cyc), 32'h2); chk("abort_stall", 32'(m_stall), 32'h0); tick();

      // Reset with two outstanding
      req(1'b1, 1'b1, 30'h030); settle(); tick(); settle(); tick();
      rst = 1'b1; stb = 1'b0; settle(); tick();
      rst = 1'b0; cyc = 1'b0; settle();
      chk("rst2_cyc", 32'(s_cyc), 32'h0); chk("rst2_err", 32'(m_err), 32'h0); tick();
      req(1'b1, 1'b0, 30'h104); settle(); chk("rst2_cnt0", 32'(s_cyc), 32'h2); tick();

      // Overlapping windows: lowest index wins
      req(1'b1, 1'b1, 30'h410); settle(); chk("prio_s2", 32'(s_stb), 32'h4); tick();
      stb = 1'b0; s_ack[2] = 1'b1; settle(); tick(); s_ack = '0;
      req(1'b1, 1'b1, 30'h5F0); settle(); chk("prio_s3", 32'(s_stb), 32'h8); tick();
      stb = 1'b0; s_ack[3] = 1'b1; settle(); tick(); s_ack = '0;

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [AW-1:0] pick[7];
         pick = '{30'h004, 30'h120, 30'h410, 30'h5F0, 30'h300, 30'h800, 30'h7FC};
         rst  = ($urandom_range(0, 99) == 0);
         cyc  = ($urandom_range(0, 15) != 0);
         stb  = $urandom_range(0, 1);
         we   = $urandom_range(0, 1);
         sel  = 4'($urandom);
         wdat = $urandom;
         addr = pick[$urandom_range(0, 6)];
         for (int k = 0; k < NS; k++) begin
            s_ack[k]   = ($urandom_range(0, 2) == 0);
            s_err[k]   = ($urandom_range(0, 9) == 0);
            s_stall[k] = ($urandom_range(0, 3) == 0);
            s_data[k]  = $urandom;
         end
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
